// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch FSM states, widths and reset/bubble defaults
// used by the fetch stage and the downstream pipeline registers.
package pipe_pkg;

    localparam int PIPE_ADDR_W = 32;
    localparam int PIPE_INST_W = 32;

    localparam logic [PIPE_ADDR_W-1:0] DEF_RESET_PC = '0;
    localparam logic [PIPE_INST_W-1:0] DEF_NOP_INST = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FULL  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction, inserts a bubble,
// or holds its contents when neither control is active.
module if_id_reg
    import pipe_pkg::*;
#(
    parameter int                ADDR_W   = PIPE_ADDR_W,
    parameter int                DATA_W   = PIPE_INST_W,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(DEF_NOP_INST)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              bubble,
    input  logic [DATA_W-1:0] inst_in,
    input  logic [ADDR_W-1:0] pc4_in,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] pc4,
    output logic              valid
);

    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d;

    // Bubble wins over load so a flush can never let an instruction through.
    always_comb begin
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (bubble) begin
            inst_d  = NOP_INST;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (load) begin
            inst_d  = inst_in;
            pc4_d   = pc4_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q  <= NOP_INST;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign inst  = inst_q;
    assign pc4   = pc4_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, a one-entry fetch buffer and the IF/ID register,
// and talks to a variable-latency instruction memory over req/ack.
module fetch_stage
    import pipe_pkg::*;
#(
    parameter int                ADDR_W   = PIPE_ADDR_W,
    parameter int                DATA_W   = PIPE_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(DEF_NOP_INST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCWrite,
    input  logic              IF_ID_Write,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectPC,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] IF_ID_Inst,
    output logic [ADDR_W-1:0] IF_ID_PC4,
    output logic              IF_ID_Valid,
    output logic              FetchStall
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] buf_q, buf_d;

    logic              avail;
    logic              deliver;
    logic              ifid_bubble;
    logic [ADDR_W-1:0] pc_plus4;
    logic [DATA_W-1:0] deliver_inst;

    always_comb begin
        avail        = ((state_q == S_FETCH) && imem_ack) || (state_q == S_FULL);
        deliver      = avail && PCWrite && IF_ID_Write && !Redirect;
        ifid_bubble  = Redirect || (IF_ID_Write && !deliver);
        pc_plus4     = pc_q + ADDR_W'(4);
        deliver_inst = (state_q == S_FULL) ? buf_q : imem_rdata;
        FetchStall   = IF_ID_Write && !avail && !Redirect;

        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;

        if (Redirect) begin
            pc_d  = RedirectPC & ~ADDR_W'(3);
            buf_d = NOP_INST;
            // An unacknowledged access must still complete before the new PC goes out.
            if ((state_q == S_FETCH || state_q == S_DRAIN) && !imem_ack)
                state_d = S_DRAIN;
            else
                state_d = S_FETCH;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        if (deliver) begin
                            pc_d = pc_plus4;
                        end else begin
                            buf_d   = imem_rdata;
                            state_d = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (deliver) begin
                        pc_d    = pc_plus4;
                        state_d = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack)
                        state_d = S_FETCH;
                end
                default: state_d = S_IDLE;
            endcase
        end

        req_d  = (state_d == S_FETCH) || (state_d == S_DRAIN);
        // While draining, the memory still sees the killed address, not the new PC.
        addr_d = (state_d == S_DRAIN) ? addr_q : pc_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            buf_q   <= NOP_INST;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            buf_q   <= buf_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;

    if_id_reg #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst),
        .load    (deliver),
        .bubble  (ifid_bubble),
        .inst_in (deliver_inst),
        .pc4_in  (pc_plus4),
        .inst    (IF_ID_Inst),
        .pc4     (IF_ID_PC4),
        .valid   (IF_ID_Valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a transaction-level model predicts each IF/ID
// update into a queue, and a monitor compares it after every rising edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite, IF_ID_Write, Redirect;
    logic [31:0] RedirectPC;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] IF_ID_Inst, IF_ID_PC4;
    logic        IF_ID_Valid, FetchStall;

    fetch_stage #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0),
        .NOP_INST (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PCWrite     (PCWrite),
        .IF_ID_Write (IF_ID_Write),
        .Redirect    (Redirect),
        .RedirectPC  (RedirectPC),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .IF_ID_Inst  (IF_ID_Inst),
        .IF_ID_PC4   (IF_ID_PC4),
        .IF_ID_Valid (IF_ID_Valid),
        .FetchStall  (FetchStall)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    ifid_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    // Reference model: next program-order PC, a pending killed access, a held response.
    logic [31:0] m_pc;
    bit          m_kill;
    bit          m_buf;
    ifid_t       m_last;
    // Memory responder bookkeeping.
    bit          in_req;
    int          wait_cnt;
    bit          prev_req, prev_ack;
    logic [31:0] prev_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = 32'h0;
        m_kill   = 0;
        m_buf    = 0;
        m_last   = '{inst: 32'h0, pc4: 32'h0, valid: 1'b0};
        in_req   = 0;
        wait_cnt = 0;
        prev_req = 0;
        prev_ack = 0;
        prev_addr = 32'h0;
    endtask

    // One cycle of stimulus, driven at the falling edge, plus the predicted IF/ID result.
    task automatic cycle(input int lat_lo, input int lat_hi, input int stall_pct,
                         input int redir_pct, input bit force_redir,
                         input logic [31:0] force_tgt, input bit force_hold);
        bit    ack, live, avail;
        int    r;
        ifid_t e;
        @(negedge clk);
        ack = 0;
        if (imem_req) begin
            if (!in_req) begin
                in_req   = 1;
                wait_cnt = $urandom_range(lat_hi, lat_lo);
            end
            if (wait_cnt == 0) begin
                ack    = 1;
                in_req = 0;
            end else begin
                wait_cnt--;
            end
        end else begin
            in_req = 0;
        end
        imem_ack   = ack;
        imem_rdata = ack ? mem_word(imem_addr) : $urandom;

        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        r = $urandom_range(99, 0);
        if (force_hold) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
        end else if (r < stall_pct) begin
            case ($urandom_range(2, 0))
                0: begin PCWrite = 1'b0; IF_ID_Write = 1'b0; end
                1: PCWrite = 1'b0;
                default: IF_ID_Write = 1'b0;
            endcase
        end
        Redirect   = force_redir || ($urandom_range(99, 0) < redir_pct);
        RedirectPC = force_redir ? force_tgt : $urandom;

        #1;
        live  = ack && !m_kill;
        avail = live || m_buf;
        check("fetch_stall", {31'b0, FetchStall}, {31'b0, IF_ID_Write & ~avail & ~Redirect});
        if (m_buf)
            check("req_low_when_buffered", {31'b0, imem_req}, 32'h0);
        if (prev_req && !prev_ack && imem_req)
            check("addr_stable", imem_addr, prev_addr);
        prev_req  = imem_req;
        prev_ack  = ack;
        prev_addr = imem_addr;

        if (Redirect) begin
            e     = '{inst: 32'h0, pc4: 32'h0, valid: 1'b0};
            m_pc  = RedirectPC & ~32'd3;
            m_buf = 0;
            if (ack)
                m_kill = 0;
            else if (in_req)
                m_kill = 1;
        end else begin
            if (ack && m_kill)
                m_kill = 0;
            if (avail && PCWrite && IF_ID_Write) begin
                e     = '{inst: mem_word(m_pc), pc4: m_pc + 32'd4, valid: 1'b1};
                m_pc  = m_pc + 32'd4;
                m_buf = 0;
            end else begin
                e = IF_ID_Write ? '{inst: 32'h0, pc4: 32'h0, valid: 1'b0} : m_last;
                if (live)
                    m_buf = 1;
            end
        end
        m_last = e;
        exp_q.push_back(e);
    endtask

    // Monitor: each rising edge consumes one predicted IF/ID state.
    initial begin
        ifid_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ifid_inst", IF_ID_Inst, e.inst);
                check("ifid_pc4", IF_ID_PC4, e.pc4);
                check("ifid_valid", {31'b0, IF_ID_Valid}, {31'b0, e.valid});
                $display("cycle %0t: inst=%h pc4=%h valid=%0b (exp %h %h %0b)",
                         $time, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid, e.inst, e.pc4, e.valid);
            end
        end
    end

    initial begin
        rst         = 1'b1;
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        Redirect    = 1'b0;
        RedirectPC  = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        model_reset();

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b0;
        #1;
        check("reset_req", {31'b0, imem_req}, 32'h0);
        check("reset_valid", {31'b0, IF_ID_Valid}, 32'h0);
        check("reset_inst", IF_ID_Inst, 32'h0);
        check("reset_pc4", IF_ID_PC4, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Zero-wait memory, no stalls.
        repeat (12) cycle(0, 0, 0, 0, 0, 32'h0, 0);
        // Three-cycle memory latency.
        repeat (16) cycle(3, 3, 0, 0, 0, 32'h0, 0);
        // Hazard stalls with short latencies.
        repeat (40) cycle(0, 2, 35, 0, 0, 32'h0, 0);

        // Redirect to an unaligned target while a long request is outstanding.
        for (int i = 0; i < 20; i++) begin
            cycle(4, 4, 0, 0, 0, 32'h0, 0);
            if (in_req && wait_cnt > 1) break;
        end
        cycle(4, 4, 0, 0, 1, 32'h0000_0103, 0);
        repeat (14) cycle(1, 1, 0, 0, 0, 32'h0, 0);

        // Redirect coincident with a hold and a zero-wait ack.
        repeat (3) cycle(0, 0, 0, 0, 0, 32'h0, 0);
        cycle(0, 0, 0, 0, 1, 32'h0000_0200, 1);
        repeat (4) cycle(0, 0, 0, 0, 0, 32'h0, 0);

        // PC wrap-around at the top of the address space.
        cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        repeat (5) cycle(0, 0, 0, 0, 0, 32'h0, 0);

        // Mixed random traffic.
        repeat (300) cycle(0, 3, 25, 5, 0, 32'h0, 0);

        // Reset asserted while a request waits on memory.
        for (int i = 0; i < 20; i++) begin
            cycle(5, 5, 0, 0, 0, 32'h0, 0);
            if (in_req && wait_cnt > 1) break;
        end
        @(posedge clk);
        #2 rst = 1'b0;
        imem_ack = 1'b0;
        #1;
        check("midwait_reset_req", {31'b0, imem_req}, 32'h0);
        check("midwait_reset_valid", {31'b0, IF_ID_Valid}, 32'h0);
        check("midwait_reset_pc4", IF_ID_PC4, 32'h0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (10) cycle(0, 0, 0, 0, 0, 32'h0, 0);

        repeat (2) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
